// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32IM pipeline: load-use bubbles,
// taken-branch flushes, multi-cycle MUL/DIV holds, memory freezes and a stall counter.
module pipeline_hazard_ctrl #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 33
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [4:0]  ID_RS1,
  input  logic [4:0]  ID_RS2,
  input  logic        ID_USES_RS1,
  input  logic        ID_USES_RS2,
  input  logic [4:0]  EX_DEST_REG,
  input  logic        EX_IS_LOAD,
  input  logic        EX_BRANCH_TAKEN,
  input  logic        EX_IS_MUL,
  input  logic        EX_IS_DIV,
  input  logic        MEM_BUSY,
  output logic        PC_ENABLE,
  output logic        IF_ID_ENABLE,
  output logic        ID_EX_ENABLE,
  output logic        EX_MEM_ENABLE,
  output logic        MEM_WB_ENABLE,
  output logic        IF_ID_FLUSH,
  output logic        ID_EX_BUBBLE,
  output logic        EX_MEM_BUBBLE,
  output logic        PC_SEL_TARGET,
  output logic        MULDIV_BUSY,
  output logic [31:0] STALL_CYCLES
);

  typedef enum logic {RUN, MD_WAIT} state_e;

  localparam bit MUL_STALLS = (MUL_CYCLES > 1);
  localparam bit DIV_STALLS = (DIV_CYCLES > 1);
  // CNT counts the remaining wait cycles after the entry cycle and the release cycle.
  localparam logic [5:0] MUL_PRESET = MUL_STALLS ? 6'(MUL_CYCLES - 2) : 6'd0;
  localparam logic [5:0] DIV_PRESET = DIV_STALLS ? 6'(DIV_CYCLES - 2) : 6'd0;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] stall_cycles_q;

  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_bubble, ex_mem_bubble, pc_sel;
  logic load_use, md_start;

  assign load_use = EX_IS_LOAD && (EX_DEST_REG != 5'd0) &&
                    ((ID_USES_RS1 && (ID_RS1 == EX_DEST_REG)) ||
                     (ID_USES_RS2 && (ID_RS2 == EX_DEST_REG)));
  assign md_start = (EX_IS_MUL && MUL_STALLS) || (EX_IS_DIV && DIV_STALLS);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    mem_wb_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    pc_sel        = 1'b0;

    if (MEM_BUSY) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (state_q == RUN && EX_BRANCH_TAKEN) begin
      pc_sel       = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if ((state_q == RUN && md_start) || (state_q == MD_WAIT && cnt_q != 6'd0)) begin
      // Hold the front end and EX; let older instructions drain behind a bubble.
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_bubble = 1'b1;
      if (state_q == RUN) begin
        cnt_d   = EX_IS_DIV ? DIV_PRESET : MUL_PRESET;
        state_d = MD_WAIT;
      end else begin
        cnt_d = cnt_q - 6'd1;
      end
    end else if (state_q == MD_WAIT) begin
      state_d = RUN;
    end else if (load_use) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; RESET is asynchronous.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q        <= RUN;
      cnt_q          <= 6'd0;
      stall_cycles_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!pc_en) stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  // Reset forces a fully frozen, quiet pipeline regardless of the hazard inputs.
  assign PC_ENABLE     = pc_en         && !RESET;
  assign IF_ID_ENABLE  = if_id_en      && !RESET;
  assign ID_EX_ENABLE  = id_ex_en      && !RESET;
  assign EX_MEM_ENABLE = ex_mem_en     && !RESET;
  assign MEM_WB_ENABLE = mem_wb_en     && !RESET;
  assign IF_ID_FLUSH   = if_id_flush   && !RESET;
  assign ID_EX_BUBBLE  = id_ex_bubble  && !RESET;
  assign EX_MEM_BUBBLE = ex_mem_bubble && !RESET;
  assign PC_SEL_TARGET = pc_sel        && !RESET;
  assign MULDIV_BUSY   = (state_q == MD_WAIT) && !RESET;
  assign STALL_CYCLES  = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a cycle-level behavioural model checked
// every negedge, plus literal expectations for load-use, MUL/DIV, MEM_BUSY and reset.
module tb_pipeline_hazard_ctrl;

  localparam int MUL_N = 2;
  localparam int DIV_N = 33;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [4:0]  ID_RS1, ID_RS2, EX_DEST_REG;
  logic        ID_USES_RS1, ID_USES_RS2;
  logic        EX_IS_LOAD, EX_BRANCH_TAKEN, EX_IS_MUL, EX_IS_DIV, MEM_BUSY;
  logic        PC_ENABLE, IF_ID_ENABLE, ID_EX_ENABLE, EX_MEM_ENABLE, MEM_WB_ENABLE;
  logic        IF_ID_FLUSH, ID_EX_BUBBLE, EX_MEM_BUBBLE, PC_SEL_TARGET, MULDIV_BUSY;
  logic [31:0] STALL_CYCLES;

  int n_vec  = 0;
  int n_miss = 0;

  pipeline_hazard_ctrl #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .CLK(CLK), .RESET(RESET),
    .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
    .ID_USES_RS1(ID_USES_RS1), .ID_USES_RS2(ID_USES_RS2),
    .EX_DEST_REG(EX_DEST_REG), .EX_IS_LOAD(EX_IS_LOAD),
    .EX_BRANCH_TAKEN(EX_BRANCH_TAKEN), .EX_IS_MUL(EX_IS_MUL), .EX_IS_DIV(EX_IS_DIV),
    .MEM_BUSY(MEM_BUSY),
    .PC_ENABLE(PC_ENABLE), .IF_ID_ENABLE(IF_ID_ENABLE), .ID_EX_ENABLE(ID_EX_ENABLE),
    .EX_MEM_ENABLE(EX_MEM_ENABLE), .MEM_WB_ENABLE(MEM_WB_ENABLE),
    .IF_ID_FLUSH(IF_ID_FLUSH), .ID_EX_BUBBLE(ID_EX_BUBBLE), .EX_MEM_BUBBLE(EX_MEM_BUBBLE),
    .PC_SEL_TARGET(PC_SEL_TARGET), .MULDIV_BUSY(MULDIV_BUSY), .STALL_CYCLES(STALL_CYCLES)
  );

  always #5 CLK = ~CLK;

  // {PC, IF_ID, ID_EX, EX_MEM, MEM_WB enables, IF_ID_FLUSH, ID_EX_BUBBLE, EX_MEM_BUBBLE, PC_SEL, MULDIV_BUSY}
  logic [9:0] ctl_vec;
  assign ctl_vec = {PC_ENABLE, IF_ID_ENABLE, ID_EX_ENABLE, EX_MEM_ENABLE, MEM_WB_ENABLE,
                    IF_ID_FLUSH, ID_EX_BUBBLE, EX_MEM_BUBBLE, PC_SEL_TARGET, MULDIV_BUSY};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an op in EX of length m_len has finished m_done of its occupancy cycles.
  int          m_len = 0;
  int          m_done = 0;
  logic [31:0] m_stall = 32'd0;
  int          preset_tag = 0;
  int          preset_seen = 0;

  function automatic int op_len();
    if (EX_IS_DIV) return DIV_N;
    if (EX_IS_MUL) return MUL_N;
    return 1;
  endfunction

  function automatic logic [9:0] expect_ctl();
    bit in_md, holding, lu;
    in_md   = (m_len != 0);
    holding = (!in_md && op_len() > 1) || (in_md && (m_done + 1 < m_len));
    lu      = EX_IS_LOAD && (EX_DEST_REG != 5'd0) &&
              ((ID_USES_RS1 && ID_RS1 == EX_DEST_REG) || (ID_USES_RS2 && ID_RS2 == EX_DEST_REG));
    if (RESET)                      return 10'b0;
    if (MEM_BUSY)                   return {9'b0, in_md};
    if (!in_md && EX_BRANCH_TAKEN)  return 10'b11111_11010;
    if (holding)                    return {5'b00011, 4'b0010, in_md};
    if (in_md)                      return 10'b11111_00001;
    if (lu)                         return 10'b00111_01000;
    return 10'b11111_00000;
  endfunction

  function automatic logic [31:0] expect_stall();
    return (preset_tag != preset_seen) ? 32'hFFFF_FFFF : m_stall;
  endfunction

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_len       = 0;
      m_done      = 0;
      m_stall     = 32'd0;
      preset_seen = preset_tag;
    end else begin
      m_stall     = expect_stall();
      preset_seen = preset_tag;
      if (!expect_ctl()[9]) m_stall = m_stall + 32'd1;
      if (!MEM_BUSY) begin
        if (m_len != 0) begin
          m_done++;
          if (m_done >= m_len) begin
            m_len  = 0;
            m_done = 0;
          end
        end else if (op_len() > 1 && !EX_BRANCH_TAKEN) begin
          m_len  = op_len();
          m_done = 1;
        end
      end
    end
  end

  always @(negedge CLK) begin
    check("ctl", {22'd0, ctl_vec}, {22'd0, expect_ctl()});
    check("stall_cycles", STALL_CYCLES, expect_stall());
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got time %0t expected < 100000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    ID_RS1 = 5'd0; ID_RS2 = 5'd0; ID_USES_RS1 = 1'b0; ID_USES_RS2 = 1'b0;
    EX_DEST_REG = 5'd0; EX_IS_LOAD = 1'b0; EX_BRANCH_TAKEN = 1'b0;
    EX_IS_MUL = 1'b0; EX_IS_DIV = 1'b0; MEM_BUSY = 1'b0;
  endtask

  // Hold a MUL/DIV in EX until its release cycle; optionally freeze memory or
  // present a (to-be-ignored) taken branch at chosen relative cycles.
  task automatic run_op(input bit is_div, input int busy_from, input int busy_len,
                        input int br_at, output int occ, output int pc_low, output int md);
    bit done;
    occ = 0; pc_low = 0; md = 0; done = 1'b0;
    EX_IS_DIV = is_div;
    EX_IS_MUL = !is_div;
    for (int k = 0; k < 200; k++) begin
      MEM_BUSY        = (k >= busy_from) && (k < busy_from + busy_len);
      EX_BRANCH_TAKEN = (k == br_at);
      @(negedge CLK);
      occ++;
      if (!PC_ENABLE) pc_low++;
      if (MULDIV_BUSY) md++;
      done = MULDIV_BUSY && PC_ENABLE;
      tick();
      if (done) break;
    end
    if (!done) check("op_release_timeout", 32'd0, 32'd1);
    clear_inputs();
  endtask

  int occ, pc_low, md;
  logic [31:0] s0;

  initial begin
    RESET = 1'b1;
    clear_inputs();
    tick();
    @(negedge CLK);
    check("reset_pc_enable", {31'd0, PC_ENABLE}, 32'd0);
    check("reset_stall_cycles", STALL_CYCLES, 32'd0);
    tick();
    RESET = 1'b0;
    @(negedge CLK);
    check("idle_ctl", {22'd0, ctl_vec}, 32'h3E0);

    // Load-use on rs2: one bubble, then normal flow.
    tick();
    EX_IS_LOAD = 1'b1; EX_DEST_REG = 5'd5; ID_RS2 = 5'd5; ID_USES_RS2 = 1'b1;
    @(negedge CLK);
    check("lu_pc_enable", {31'd0, PC_ENABLE}, 32'd0);
    check("lu_id_ex_bubble", {31'd0, ID_EX_BUBBLE}, 32'd1);
    tick();
    clear_inputs();
    @(negedge CLK);
    check("lu_after_pc_enable", {31'd0, PC_ENABLE}, 32'd1);
    check("lu_stall_count", STALL_CYCLES, 32'd1);

    // Load-use on rs1.
    tick();
    EX_IS_LOAD = 1'b1; EX_DEST_REG = 5'd12; ID_RS1 = 5'd12; ID_USES_RS1 = 1'b1;
    @(negedge CLK);
    check("lu_rs1_pc_enable", {31'd0, PC_ENABLE}, 32'd0);
    tick();

    // Load to x0 never stalls.
    EX_IS_LOAD = 1'b1; EX_DEST_REG = 5'd0; ID_RS1 = 5'd0; ID_USES_RS1 = 1'b1;
    ID_RS2 = 5'd0; ID_USES_RS2 = 1'b1;
    @(negedge CLK);
    check("x0_no_stall", {31'd0, PC_ENABLE}, 32'd1);
    tick();

    // Match only on an operand the instruction does not read.
    clear_inputs();
    EX_IS_LOAD = 1'b1; EX_DEST_REG = 5'd7; ID_RS1 = 5'd7; ID_USES_RS1 = 1'b0;
    ID_RS2 = 5'd3; ID_USES_RS2 = 1'b1;
    @(negedge CLK);
    check("unused_rs_no_stall", {31'd0, PC_ENABLE}, 32'd1);
    tick();

    // Taken branch coincident with a load-use match.
    clear_inputs();
    EX_IS_LOAD = 1'b1; EX_DEST_REG = 5'd9; ID_RS1 = 5'd9; ID_USES_RS1 = 1'b1;
    EX_BRANCH_TAKEN = 1'b1;
    @(negedge CLK);
    check("br_lu_ctl", {22'd0, ctl_vec}, 32'h3FA);
    tick();

    // MEM_BUSY with a branch pending: everything frozen, no redirect.
    clear_inputs();
    EX_BRANCH_TAKEN = 1'b1; MEM_BUSY = 1'b1;
    @(negedge CLK);
    check("mem_busy_ctl", {22'd0, ctl_vec}, 32'h000);
    tick();
    clear_inputs();

    // MUL: two cycles in EX, one stall.
    s0 = STALL_CYCLES;
    run_op(1'b0, -1, 0, -1, occ, pc_low, md);
    check("mul_occupancy", occ, 32'd2);
    check("mul_pc_low", pc_low, 32'd1);
    check("mul_stall_delta", STALL_CYCLES - s0, 32'd1);

    // DIV: 33 cycles in EX, 32 stalls, 32 cycles in MD_WAIT.
    s0 = STALL_CYCLES;
    run_op(1'b1, -1, 0, -1, occ, pc_low, md);
    check("div_occupancy", occ, 32'd33);
    check("div_pc_low", pc_low, 32'd32);
    check("div_md_cycles", md, 32'd32);
    check("div_stall_delta", STALL_CYCLES - s0, 32'd32);

    // DIV with a 3-cycle memory freeze and an ignored branch mid-wait.
    run_op(1'b1, 5, 3, 10, occ, pc_low, md);
    check("div_busy_occupancy", occ, 32'd36);
    check("div_busy_pc_low", pc_low, 32'd35);

    // RESET pulse in the middle of MD_WAIT.
    EX_IS_DIV = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    @(negedge CLK);
    #2 RESET = 1'b1;
    #1;
    check("rst_md_busy", {31'd0, MULDIV_BUSY}, 32'd0);
    check("rst_stall_zero", STALL_CYCLES, 32'd0);
    check("rst_pc_enable", {31'd0, PC_ENABLE}, 32'd0);
    clear_inputs();
    tick();
    tick();
    RESET = 1'b0;
    @(negedge CLK);
    check("post_rst_run", {22'd0, ctl_vec}, 32'h3E0);

    // Counter preset to all-ones wraps to zero on the next stall cycle.
    tick();
    force dut.stall_cycles_q = 32'hFFFF_FFFF;
    #1 release dut.stall_cycles_q;
    preset_tag++;
    EX_IS_LOAD = 1'b1; EX_DEST_REG = 5'd5; ID_RS2 = 5'd5; ID_USES_RS2 = 1'b1;
    @(negedge CLK);
    check("preset_value", STALL_CYCLES, 32'hFFFF_FFFF);
    tick();
    clear_inputs();
    @(negedge CLK);
    check("stall_wrap", STALL_CYCLES, 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
